config_loader: RTL and testbench

//   Bitstream loader that sits directly upstream of the configuration shift-register chain
//   (io_block / logic-block config_mem instances).
//   - Accepts config words over a valid/ready stream.
//   - Serialises them, LSB first, onto the chain's serial input with a matching shift enable.
//   - Stops after exactly CHAIN_LEN bits.
//   - Captures the old chain contents emerging at the chain tail as readback words.

---
 rtl/config_loader.sv | 145 ++++++++++++++
 tb/tb_config_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Serialises config words LSB-first onto the configuration chain and captures the
// previous chain contents emerging at the tail as readback words.
module config_loader #(
    parameter int CHAIN_LEN  = 16,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  config_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  chain_en,
    output logic                  chain_in,
    input  logic                  chain_out,
    output logic [WORD_WIDTH-1:0] rb_data,
    output logic                  rb_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int IW = $clog2(WORD_WIDTH) + 1;
    localparam logic [CW-1:0] LEN      = CW'(CHAIN_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

    state_t                state, state_d;
    logic [CW-1:0]         total, total_inc;
    logic [IW-1:0]         bit_idx;
    logic [WORD_WIDTH-1:0] word_sr, word_next;
    logic [WORD_WIDTH-1:0] rb_sr, rb_next, rb_data_q;
    logic                  en_q, in_q, rb_valid_q, aborted_q;
    logic                  en_d, in_d;
    logic                  accept, step, last_bit, start_ok, do_abort;

    always_comb begin
        state_d   = state;
        en_d      = 1'b0;
        in_d      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        start_ok  = 1'b0;
        do_abort  = 1'b0;
        total_inc = total + 1'b1;
        word_next = word_sr >> 1;
        last_bit  = (bit_idx == LAST_IDX) || (total_inc == LEN);
        rb_next   = rb_sr | (WORD_WIDTH'(chain_out) << bit_idx);
        // chain_en/chain_in are computed one cycle ahead so the registered copies line up with SHIFT
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = WAIT_WORD;
                    start_ok = 1'b1;
                end
            end
            WAIT_WORD: begin
                if (abort) begin
                    state_d  = IDLE;
                    do_abort = 1'b1;
                end else if (s_valid) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                    en_d    = 1'b1;
                    in_d    = s_data[0];
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d  = IDLE;
                    do_abort = 1'b1;
                end else begin
                    step = 1'b1;
                    if (last_bit) begin
                        state_d = (total_inc == LEN) ? DONE : WAIT_WORD;
                    end else begin
                        en_d = 1'b1;
                        in_d = word_next[0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge config_clk) begin
        if (reset) begin
            state      <= IDLE;
            total      <= '0;
            bit_idx    <= '0;
            word_sr    <= '0;
            rb_sr      <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
            en_q       <= 1'b0;
            in_q       <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state      <= state_d;
            en_q       <= en_d;
            in_q       <= in_d;
            rb_valid_q <= 1'b0;
            if (start_ok) begin
                total     <= '0;
                bit_idx   <= '0;
                rb_sr     <= '0;
                aborted_q <= 1'b0;
            end
            if (do_abort) begin
                bit_idx   <= '0;
                rb_sr     <= '0;
                aborted_q <= 1'b1;
            end
            if (accept) begin
                word_sr <= s_data;
                bit_idx <= '0;
            end
            // en_q is high exactly in SHIFT, so chain_out is sampled here at bit position bit_idx
            if (step) begin
                total   <= total_inc;
                word_sr <= word_next;
                if (last_bit) begin
                    bit_idx    <= '0;
                    rb_sr      <= '0;
                    rb_data_q  <= rb_next;
                    rb_valid_q <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 1'b1;
                    rb_sr   <= rb_next;
                end
            end
        end
    end

    assign s_ready  = (state == WAIT_WORD) && !abort;
    assign chain_en = en_q;
    assign chain_in = in_q;
    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
    assign busy     = (state == WAIT_WORD) || (state == SHIFT);
    assign done     = (state == DONE);
    assign aborted  = aborted_q;
endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader driving a behavioural chain; expected bits and
// readback words are queued by the stimulus and consumed by an independent monitor.
module tb_config_loader;
    localparam int L  = 20;
    localparam int W  = 8;
    localparam int NW = (L + W - 1) / W;

    logic         clk = 1'b0;
    logic         reset, start, abort, s_valid;
    logic [W-1:0] s_data;
    logic         s_ready, chain_en, chain_in, chain_out;
    logic [W-1:0] rb_data;
    logic         rb_valid, busy, done, aborted;

    always #5 clk = ~clk;

    config_loader #(.CHAIN_LEN(L), .WORD_WIDTH(W)) dut (
        .config_clk(clk), .reset(reset), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .chain_en(chain_en), .chain_in(chain_in), .chain_out(chain_out),
        .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .done(done),
        .aborted(aborted)
    );

    // Physical chain: element 0 takes chain_in, element L-1 is the tail
    logic [L-1:0] chain_m;
    logic         preload = 1'b0;
    logic [L-1:0] preload_val;
    always @(posedge clk) begin
        if (preload) chain_m <= preload_val;
        else if (chain_en) chain_m <= {chain_m[L-2:0], chain_in};
    end
    assign chain_out = chain_m[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           n_checks = 0;
    int           n_fail   = 0;
    bit           exp_bits[$];
    logic [W-1:0] exp_rb[$];
    bit           ref_stream[$];   // order in which current chain bits will emerge
    bit           new_stream[$];
    logic [W-1:0] ld_words[NW];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chain_en) begin
            n_checks++;
            if (exp_bits.size() == 0) begin
                n_fail++;
                $display("FAIL chain_en: got 1 expected 0 (no bit pending, t=%0t)", $time);
            end else if (chain_in !== exp_bits[0]) begin
                n_fail++;
                $display("FAIL chain_in: got %0b expected %0b (t=%0t)", chain_in, exp_bits[0], $time);
            end
            if (exp_bits.size() != 0) void'(exp_bits.pop_front());
        end
        if (rb_valid) begin
            n_checks++;
            if (exp_rb.size() == 0) begin
                n_fail++;
                $display("FAIL rb_valid: got 1 expected 0 (no word pending, t=%0t)", $time);
            end else if (rb_data !== exp_rb[0]) begin
                n_fail++;
                $display("FAIL rb_data: got 0x%0h expected 0x%0h (t=%0t)", rb_data, exp_rb[0], $time);
            end
            if (exp_rb.size() != 0) void'(exp_rb.pop_front());
        end
    end

    task automatic refresh_ref();
        ref_stream.delete();
        for (int i = 0; i < L; i++) ref_stream.push_back(chain_m[L-1-i]);
    endtask

    task automatic do_preload(input logic [L-1:0] val);
        preload_val = val;
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
        refresh_ref();
    endtask

    task automatic pulse_start(input bit with_abort);
        start = 1'b1;
        abort = with_abort;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        bit ok = 0;
        int to = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (!ok && to < 200) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            to++;
        end
        #1;
        s_valid = 1'b0;
        s_data  = W'($urandom);
        if (!ok) check("s_ready_timeout", 0, 1);
    endtask

    task automatic push_word_bits(input logic [W-1:0] w, input int sent);
        int take = (L - sent < W) ? (L - sent) : W;
        for (int j = 0; j < take; j++) begin
            exp_bits.push_back(w[j]);
            new_stream.push_back(w[j]);
        end
    endtask

    task automatic do_load(input bit with_abort, input int max_gap);
        int c0;
        bit ok = 0;
        logic [W-1:0] rw;
        pulse_start(with_abort);
        c0 = cyc;
        check("busy_after_start", busy, 1);
        check("aborted_cleared", aborted, 0);
        check("done_dropped", done, 0);
        for (int k = 0; k < NW; k++) begin
            rw = '0;
            for (int j = 0; j < W; j++)
                if (k * W + j < L) rw[j] = ref_stream[k * W + j];
            exp_rb.push_back(rw);
        end
        new_stream.delete();
        for (int k = 0; k < NW; k++) begin
            push_word_bits(ld_words[k], k * W);
            send_word(ld_words[k]);
            repeat ($urandom_range(0, max_gap)) @(posedge clk);
            #1;
        end
        for (int n = 0; n < 300 && !ok; n++) begin
            if (done) ok = 1;
            else begin @(posedge clk); #1; end
        end
        check("done_reached", ok, 1);
        if (max_gap == 0) check("load_cycles", cyc - c0, NW + L);
        check("s_ready_in_done", s_ready, 0);
        check("busy_in_done", busy, 0);
        @(negedge clk); #1;
        check("bits_left", exp_bits.size(), 0);
        check("rb_left", exp_rb.size(), 0);
        ref_stream = new_stream;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        preload_val = L'($urandom);
        preload = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        reset = 1'b0;
        refresh_ref();
        check("rst_chain_en", chain_en, 0);
        check("rst_chain_in", chain_in, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_rb_valid", rb_valid, 0);
        check("rst_rb_data", rb_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);

        // back-to-back words, then same load with idle gaps
        ld_words = '{8'hA5, 8'h3C, 8'h0F};
        do_load(0, 0);
        do_load(0, 12);
        // partial final word: only 4 low bits of 0xFF used
        ld_words = '{8'h11, 8'h22, 8'hFF};
        do_load(0, 0);

        // known old contents emerge as readback
        do_preload('1);
        ld_words = '{8'h00, 8'h00, 8'h00};
        do_load(0, 2);
        do_load(0, 0);

        // start and abort together in DONE: start wins
        ld_words = '{W'($urandom), W'($urandom), W'($urandom)};
        do_load(1, 3);

        // abort mid-word
        pulse_start(0);
        push_word_bits(8'h96, 0);
        send_word(8'h96);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_chain_en", chain_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_flag", aborted, 1);
        exp_bits.delete();
        refresh_ref();
        @(posedge clk); #1;
        check("abort_sticky", aborted, 1);
        ld_words = '{W'($urandom), W'($urandom), W'($urandom)};
        do_load(0, 4);

        // reset mid-SHIFT, then s_valid without start is ignored
        pulse_start(0);
        push_word_bits(8'h5A, 0);
        send_word(8'h5A);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_bits.delete();
        refresh_ref();
        check("mid_rst_chain_en", chain_en, 0);
        check("mid_rst_chain_in", chain_in, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rb_valid", rb_valid, 0);
        check("mid_rst_rb_data", rb_data, 0);
        s_valid = 1'b1;
        s_data  = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_s_ready", s_ready, 0);
        end
        #1 s_valid = 1'b0;

        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < NW; k++) ld_words[k] = W'($urandom);
            do_load(bit'($urandom_range(0, 1)), $urandom_range(0, 12));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
